aes_inv_key_schedule: RTL

- Iterative AES-128 reverse key expansion for the decryption datapath.
- Takes the final round key (round 10) and streams round keys 10, 9, … 0 over a valid/ready interface, one round computed per accepted beat.
- It is the inverse of the forward key expansion: the inverse cipher consumes keys in reverse order without storing the full 176-byte schedule.

---
 rtl/aes_inv_key_schedule.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/aes_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_inv_key_schedule
//
// Iterative AES-128 reverse key expansion. Loads the round-10 key and walks
// the schedule backwards, presenting round keys 10, 9, ... 0 on a valid/ready
// stream. One previous round key is derived per accepted beat, so the full
// 176-byte schedule is never stored.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        begin a schedule (sampled only while idle)
//   last_key     round-10 key, word0 in [127:96], byte0 of each word in MSBs
//   out_valid    round_key / round_index hold a valid beat
//   out_ready    consumer accepts the current beat
//   round_key    current round key (same byte order as last_key)
//   round_index  round number of round_key, 10 down to 0
//   busy         schedule in progress (cycle after start up to last handshake)
//   done         one-cycle pulse after the round-0 key is accepted
//
// Also contains aes_sbox, the forward AES S-box used four times per round.
// ---------------------------------------------------------------------------

module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_o = SBOX[in_i];
endmodule

module aes_inv_key_schedule #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_index,
    output logic         busy,
    output logic         done
);
    // Only the AES-128 schedule is implemented.
    generate
        if (ROUNDS != 10) begin : g_bad_rounds
            $error("aes_inv_key_schedule: only ROUNDS = 10 (AES-128) is supported");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;

    // Previous-round key from the current one. Undoing the forward XOR chain
    // recovers words 1..3 directly; word 0 needs the g() function applied to
    // the recovered word 3 with the Rcon of the round being left.
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p3, rot_p3, sub_p3;
    logic [7:0]  rcon;
    logic [127:0] prev_key;

    assign {w0, w1, w2, w3} = key_q;
    assign p3     = w3 ^ w2;
    assign rot_p3 = {p3[23:0], p3[31:24]};

    aes_sbox u_sbox0 (.in_i(rot_p3[31:24]), .out_o(sub_p3[31:24]));
    aes_sbox u_sbox1 (.in_i(rot_p3[23:16]), .out_o(sub_p3[23:16]));
    aes_sbox u_sbox2 (.in_i(rot_p3[15:8]),  .out_o(sub_p3[15:8]));
    aes_sbox u_sbox3 (.in_i(rot_p3[7:0]),   .out_o(sub_p3[7:0]));

    always_comb begin
        rcon = 8'h00;
        case (idx_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign prev_key = {w0 ^ sub_p3 ^ {rcon, 24'h000000}, w1 ^ w0, w2 ^ w1, p3};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = last_key;
                    idx_d   = 4'd10;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = prev_key;
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign out_valid   = (state_q == EMIT);
    assign busy        = (state_q == EMIT);
    assign round_key   = key_q;
    assign round_index = idx_q;
    assign done        = done_q;
endmodule
